// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-port memory arbiter.
package mem_arb_pkg;

  typedef enum logic {
    ST_IDLE,
    ST_BUSY
  } arb_state_t;

  localparam int unsigned ADDR_W_DEF = 30;
  localparam int unsigned DATA_W_DEF = 32;
  localparam int unsigned RD_LAT_MAX = 7;
  localparam int unsigned CNT_W      = 3;

endpackage

// File: rtl/mem_arb_rr2.sv
// Two-input round-robin grant: a lone requester always wins, a tie goes to prio.
module arb_rr2 (
  input  logic valid0,
  input  logic valid1,
  input  logic prio,
  output logic gnt0,
  output logic gnt1
);

  // Grant at most one requester; prio picks the winner when both ask.
  always_comb begin
    gnt0 = valid0 & (~valid1 | ~prio);
    gnt1 = valid1 & (~valid0 | prio);
  end

endmodule

// File: rtl/mem_arb.sv
// Shares one memory/MMIO path between two requesters: one transaction at a
// time, fixed read latency, one response pulse back to the issuing port.
module mem_arb
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned RD_LAT = 1
) (
  input  logic              i_clk,
  input  logic              i_rst,

  input  logic              i_req0_valid,
  output logic              o_req0_ready,
  input  logic [ADDR_W-1:0] i_req0_addr,
  input  logic [DATA_W-1:0] i_req0_data,
  input  logic              i_req0_wren,
  input  logic [3:0]        i_req0_mask,
  output logic              o_rsp0_valid,
  output logic [DATA_W-1:0] o_rsp0_data,

  input  logic              i_req1_valid,
  output logic              o_req1_ready,
  input  logic [ADDR_W-1:0] i_req1_addr,
  input  logic [DATA_W-1:0] i_req1_data,
  input  logic              i_req1_wren,
  input  logic [3:0]        i_req1_mask,
  output logic              o_rsp1_valid,
  output logic [DATA_W-1:0] o_rsp1_data,

  output logic [ADDR_W-1:0] o_addr,
  output logic [DATA_W-1:0] o_data,
  output logic              o_wren,
  output logic [3:0]        o_mask,
  input  logic [DATA_W-1:0] i_data
);

  localparam logic [CNT_W-1:0] LAT_CNT = CNT_W'(RD_LAT);

  arb_state_t       state;
  logic             prio;
  logic             owner;
  logic             wren_q;
  logic [CNT_W-1:0] cnt;
  logic             gnt0;
  logic             gnt1;

  arb_rr2 u_rr (
    .valid0 (i_req0_valid),
    .valid1 (i_req1_valid),
    .prio   (prio),
    .gnt0   (gnt0),
    .gnt1   (gnt1)
  );

  // Readies are only offered while idle.
  always_comb begin
    o_req0_ready = (state == ST_IDLE) & gnt0;
    o_req1_ready = (state == ST_IDLE) & gnt1;
  end

  // Arbiter FSM: accept, hold the bus for RD_LAT+1 cycles, return the response.
  // The bus output registers double as the transaction latch; wren is kept
  // separately because o_wren is dropped after the first BUSY cycle.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state        <= ST_IDLE;
      prio         <= 1'b0;
      owner        <= 1'b0;
      wren_q       <= 1'b0;
      cnt          <= '0;
      o_addr       <= '0;
      o_data       <= '0;
      o_wren       <= 1'b0;
      o_mask       <= '0;
      o_rsp0_valid <= 1'b0;
      o_rsp1_valid <= 1'b0;
      o_rsp0_data  <= '0;
      o_rsp1_data  <= '0;
    end else begin
      o_rsp0_valid <= 1'b0;
      o_rsp1_valid <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (o_req0_ready || o_req1_ready) begin
            owner  <= o_req1_ready;
            prio   <= ~o_req1_ready;
            wren_q <= o_req1_ready ? i_req1_wren : i_req0_wren;
            o_addr <= o_req1_ready ? i_req1_addr : i_req0_addr;
            o_data <= o_req1_ready ? i_req1_data : i_req0_data;
            o_wren <= o_req1_ready ? i_req1_wren : i_req0_wren;
            o_mask <= o_req1_ready ? i_req1_mask : i_req0_mask;
            cnt    <= '0;
            state  <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          o_wren <= 1'b0;
          cnt    <= cnt + 1'b1;
          if (cnt == LAT_CNT) begin
            state  <= ST_IDLE;
            o_addr <= '0;
            o_data <= '0;
            o_mask <= '0;
            if (owner) begin
              o_rsp1_valid <= 1'b1;
              o_rsp1_data  <= wren_q ? '0 : i_data;
            end else begin
              o_rsp0_valid <= 1'b1;
              o_rsp0_data  <= wren_q ? '0 : i_data;
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arb.sv
// Directed bench for mem_arb: three instances (RD_LAT 1, 0, 3) share stimulus;
// the RD_LAT=1 instance is checked throughout, the others in the latency test.
module tb_mem_arb;

  logic        clk;
  logic        rst;
  logic        r0v, r0w, r1v, r1w;
  logic [29:0] r0a, r1a;
  logic [31:0] r0d, r1d;
  logic [3:0]  r0m, r1m;
  logic [31:0] xdata;

  logic        rdy0  [3];
  logic        rdy1  [3];
  logic        rsp0v [3];
  logic        rsp1v [3];
  logic [31:0] rsp0d [3];
  logic [31:0] rsp1d [3];
  logic [29:0] oaddr [3];
  logic [31:0] odata [3];
  logic        owren [3];
  logic [3:0]  omask [3];

  int lats [3] = '{1, 0, 3};
  int n_checks = 0;
  int n_fail   = 0;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    mem_arb #(
      .ADDR_W (30),
      .DATA_W (32),
      .RD_LAT ((g == 0) ? 1 : ((g == 1) ? 0 : 3))
    ) u_dut (
      .i_clk        (clk),
      .i_rst        (rst),
      .i_req0_valid (r0v),
      .o_req0_ready (rdy0[g]),
      .i_req0_addr  (r0a),
      .i_req0_data  (r0d),
      .i_req0_wren  (r0w),
      .i_req0_mask  (r0m),
      .o_rsp0_valid (rsp0v[g]),
      .o_rsp0_data  (rsp0d[g]),
      .i_req1_valid (r1v),
      .o_req1_ready (rdy1[g]),
      .i_req1_addr  (r1a),
      .i_req1_data  (r1d),
      .i_req1_wren  (r1w),
      .i_req1_mask  (r1m),
      .o_rsp1_valid (rsp1v[g]),
      .o_rsp1_data  (rsp1d[g]),
      .o_addr       (oaddr[g]),
      .o_data       (odata[g]),
      .o_wren       (owren[g]),
      .o_mask       (omask[g]),
      .i_data       (xdata)
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge (start of the next cycle).
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Move to the middle of the current cycle for sampling.
  task automatic mid();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    r0v = 1'b0;
    r1v = 1'b0;
    cyc();
    cyc();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    r0v = 0; r0w = 0; r0a = '0; r0d = '0; r0m = '0;
    r1v = 0; r1w = 0; r1a = '0; r1d = '0; r1m = '0;
    xdata = '0;
    #1;
    do_reset();

    // Reset state
    mid();
    chk("rst_rsp0v", rsp0v[0], 0);
    chk("rst_rsp1v", rsp1v[0], 0);
    chk("rst_rsp0d", rsp0d[0], 0);
    chk("rst_rsp1d", rsp1d[0], 0);
    chk("rst_addr",  oaddr[0], 0);
    chk("rst_data",  odata[0], 0);
    chk("rst_wren",  owren[0], 0);
    chk("rst_mask",  omask[0], 0);
    cyc();

    // Test 1: port 0 read, RD_LAT=1
    r0v = 1; r0a = 30'h10; r0w = 0; r0m = 4'hF; r0d = 32'h0; xdata = 32'h1111_1111;
    mid();
    chk("t1_rdy0_c0", rdy0[0], 1);
    chk("t1_rdy1_c0", rdy1[0], 0);
    cyc();
    r0v = 0;
    mid();
    chk("t1_addr_c1", oaddr[0], 30'h10);
    chk("t1_wren_c1", owren[0], 0);
    chk("t1_rdy0_c1", rdy0[0], 0);
    chk("t1_rsp0v_c1", rsp0v[0], 0);
    cyc();
    xdata = 32'hDEAD_BEEF;
    mid();
    chk("t1_addr_c2", oaddr[0], 30'h10);
    chk("t1_rsp0v_c2", rsp0v[0], 0);
    cyc();
    xdata = 32'h0;
    mid();
    chk("t1_rsp0v_c3", rsp0v[0], 1);
    chk("t1_rsp0d_c3", rsp0d[0], 32'hDEAD_BEEF);
    chk("t1_rsp1v_c3", rsp1v[0], 0);
    chk("t1_addr_c3", oaddr[0], 0);
    cyc();
    mid();
    chk("t1_rsp0v_c4", rsp0v[0], 0);
    chk("t1_rsp0d_hold", rsp0d[0], 32'hDEAD_BEEF);
    cyc();

    // Test 3: port 1 write
    r1v = 1; r1a = 30'h20; r1d = 32'h1234_5678; r1w = 1; r1m = 4'b0011;
    mid();
    chk("t3_rdy1_c0", rdy1[0], 1);
    chk("t3_rdy0_c0", rdy0[0], 0);
    cyc();
    r1v = 0; xdata = 32'hCAFE_F00D;
    mid();
    chk("t3_wren_c1", owren[0], 1);
    chk("t3_addr_c1", oaddr[0], 30'h20);
    chk("t3_data_c1", odata[0], 32'h1234_5678);
    chk("t3_mask_c1", omask[0], 4'b0011);
    cyc();
    mid();
    chk("t3_wren_c2", owren[0], 0);
    chk("t3_addr_c2", oaddr[0], 30'h20);
    chk("t3_mask_c2", omask[0], 4'b0011);
    chk("t3_rsp1v_c2", rsp1v[0], 0);
    cyc();
    mid();
    chk("t3_rsp1v_c3", rsp1v[0], 1);
    chk("t3_rsp1d_c3", rsp1d[0], 0);
    chk("t3_rsp0v_c3", rsp0v[0], 0);
    chk("t3_rsp0d_keep", rsp0d[0], 32'hDEAD_BEEF);
    chk("t3_data_c3", odata[0], 0);
    cyc();
    mid();
    chk("t3_rsp1v_c4", rsp1v[0], 0);
    cyc();

    // Test 2 / 6: both valid continuously, alternating grants
    do_reset();
    r0v = 1; r0a = 30'h100; r0w = 0; r0m = 4'hF;
    r1v = 1; r1a = 30'h200; r1w = 0; r1m = 4'hF;
    for (int c = 0; c <= 12; c++) begin
      xdata = 32'hD000_0000 | 32'(c);
      mid();
      chk($sformatf("t2_rdy0_c%0d", c), rdy0[0], (c % 6 == 0));
      chk($sformatf("t2_rdy1_c%0d", c), rdy1[0], (c % 6 == 3));
      chk($sformatf("t2_rsp0v_c%0d", c), rsp0v[0], (c % 6 == 3));
      chk($sformatf("t2_rsp1v_c%0d", c), rsp1v[0], (c > 0 && c % 6 == 0));
      if (c % 3 == 0)
        chk($sformatf("t2_addr_c%0d", c), oaddr[0], 0);
      else
        chk($sformatf("t2_addr_c%0d", c), oaddr[0], ((c / 3) % 2 == 0) ? 30'h100 : 30'h200);
      if (c % 6 == 3)
        chk($sformatf("t2_rsp0d_c%0d", c), rsp0d[0], 32'hD000_0000 | 32'(c - 1));
      if (c > 0 && c % 6 == 0)
        chk($sformatf("t2_rsp1d_c%0d", c), rsp1d[0], 32'hD000_0000 | 32'(c - 1));
      cyc();
    end

    // Test 5: reset in the second BUSY cycle of the port-0 txn accepted at c12
    r0v = 0; r1v = 0;
    mid();
    chk("t5_addr_c13", oaddr[0], 30'h100);
    cyc();
    rst = 1; r0v = 1; r1v = 1;
    mid();
    chk("t5_addr_c14", oaddr[0], 30'h100);
    cyc();
    rst = 0;
    mid();
    chk("t5_rsp0v_c15", rsp0v[0], 0);
    chk("t5_rsp1v_c15", rsp1v[0], 0);
    chk("t5_rsp0d_c15", rsp0d[0], 0);
    chk("t5_rsp1d_c15", rsp1d[0], 0);
    chk("t5_addr_c15", oaddr[0], 0);
    chk("t5_wren_c15", owren[0], 0);
    chk("t5_rdy0_c15", rdy0[0], 1);
    chk("t5_rdy1_c15", rdy1[0], 0);
    cyc();
    r0v = 0; r1v = 0; xdata = 32'h77;
    mid();
    chk("t5_addr_c16", oaddr[0], 30'h100);
    cyc();
    xdata = 32'h5A5A_5A5A;
    mid();
    cyc();
    mid();
    chk("t5_rsp0v_c18", rsp0v[0], 1);
    chk("t5_rsp0d_c18", rsp0d[0], 32'h5A5A_5A5A);
    chk("t5_rsp1v_c18", rsp1v[0], 0);
    cyc();

    // Test 4: latency across RD_LAT = 1, 0, 3 with data changing every cycle
    do_reset();
    r0v = 1; r0a = 30'h40; r0w = 0; r0m = 4'hF; r1v = 0;
    xdata = 32'hB000_0000;
    mid();
    for (int g = 0; g < 3; g++)
      chk($sformatf("t4_rdy0_g%0d", g), rdy0[g], 1);
    cyc();
    r0v = 0;
    for (int c = 1; c <= 6; c++) begin
      xdata = 32'hB000_0000 | 32'(c);
      mid();
      for (int g = 0; g < 3; g++) begin
        chk($sformatf("t4_rsp0v_g%0d_c%0d", g, c), rsp0v[g], (c == lats[g] + 2));
        if (c == lats[g] + 2)
          chk($sformatf("t4_rsp0d_g%0d", g), rsp0d[g], 32'hB000_0000 | 32'(lats[g] + 1));
      end
      cyc();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_arb.md
Name: mem_arb

Overview:
Two-port arbiter placed in front of mem_xbar. It shares the single data-memory/MMIO path between requester 0 (CPU load/store unit) and requester 1 (debug/DMA port). It accepts one transaction at a time over a valid/ready handshake and drives the xbar request lines. It waits a fixed memory read latency, then returns exactly one response pulse to the requester that issued the transaction. Grants alternate round-robin under contention.

Parameters:
ADDR_W, 30, word-address width (matches xbar i_addr)
DATA_W, 32, data width
RD_LAT, 1, cycles from address presented on xbar to valid i_data (legal 0..7)

Ports:
i_clk  in  1  clock
i_rst  in  1  reset; synchronous, active-high
i_req0_valid  in  1  requester 0 has a transaction
o_req0_ready  out  1  requester 0 accepted this cycle
i_req0_addr  in  ADDR_W  word address
i_req0_data  in  DATA_W  write data
i_req0_wren  in  1  1=write, 0=read
i_req0_mask  in  4  byte mask
o_rsp0_valid  out  1  one-cycle response pulse
o_rsp0_data  out  DATA_W  read data (0 for writes)
i_req1_* / o_req1_ready / o_rsp1_*  same as port 0, for requester 1
o_addr  out  ADDR_W  to xbar i_addr
o_data  out  DATA_W  to xbar i_data
o_wren  out  1  to xbar i_wren
o_mask  out  4  to xbar i_mask
i_data  in  DATA_W  from xbar o_data

Behaviour:
- Reset (i_rst=1 at edge): state=IDLE, prio=0, cnt=0, owner=0. Both rsp_valid=0, both rsp_data=0. o_addr/o_data/o_mask=0, o_wren=0. Applies mid-transaction: the in-flight txn is dropped and no response is issued.
- States: IDLE, BUSY.
- IDLE: readies are combinational from valids and prio.
  - Only one valid: that port's ready=1.
  - Both valid: port==prio gets ready=1, the other 0.
  - Readies are never both 1.
  - Requesters must not derive valid from ready.
- Accept (valid&ready at edge):
  - Latch addr/data/wren/mask and owner.
  - prio <= ~owner.
  - cnt <= 0, go to BUSY.
- BUSY: lasts RD_LAT+1 cycles. Both readies=0.
  - o_addr/o_data/o_mask = latched values for all BUSY cycles.
  - o_wren = latched wren only in the first BUSY cycle (cnt==0), 0 after, so there is exactly one write strobe.
  - cnt increments each cycle.
  - In the cycle cnt==RD_LAT: capture i_data (or 0 if write) into rsp_data[owner], set rsp_valid[owner] at the edge, return to IDLE.
- Response: rsp_valid[owner]=1 for exactly one cycle, the first IDLE cycle after BUSY. rsp_data holds its value until the next response on that port. No backpressure; requesters must take the response.
- A new accept may happen in the same cycle as a response pulse. Max throughput is one txn per RD_LAT+2 cycles.
- IDLE bus outputs: o_addr/o_data/o_mask=0, o_wren=0.
- Latency: read accepted at edge of cycle 0 → rsp_valid in cycle RD_LAT+2.
- Valid dropped without ready: no effect, no state change.
- Out-of-range addresses: passed through unchanged. The xbar returns X; the arbiter still completes and pulses the response.
- cnt is 3 bits, no wrap possible (RD_LAT≤7).

Decomposition:
- Shared package: state encodings (ST_IDLE, ST_BUSY), default ADDR_W/DATA_W, RD_LAT max constant.
- Sub-module arb_rr2: combinational two-input round-robin grant from (valid0, valid1, prio) → (gnt0, gnt1).
- FSM, latches and counter stay in mem_arb.

Test Plan:
1. RD_LAT=1; req0 read addr 0x10 with xbar i_data=0xDEADBEEF → ready0 in cycle 0; o_addr=0x10 cycles 1–2; rsp0_valid=1, rsp0_data=0xDEADBEEF in cycle 3; rsp1_valid stays 0.
2. Both valid continuously after reset → grants alternate 0,1,0,1. Each ready one cycle per 3-cycle period. Responses routed to the correct port.
3. req1 write addr 0x20 data 0x12345678 mask 4'b0011 → o_wren=1 for exactly one cycle with those values. rsp1_valid pulse with rsp1_data=0.
4. RD_LAT=0 and RD_LAT=3 builds → response arrives at cycle 2 and cycle 5 respectively after accept. Data sampled in the last BUSY cycle, not earlier.
5. i_rst asserted in the second BUSY cycle → next cycle all outputs at reset values, no rsp pulse. After release, pending req0 and req1 both valid → req0 granted first (prio=0).
6. Response cycle overlaps new accept from the other port → rsp0_valid and ready1 both 1 in the same cycle, and both transactions complete correctly.
